// File: rtl/otter_mem_pkg.sv
// Shared types and constants for the OTTER data-memory port and its arbiter.
package otter_mem_pkg;

    typedef enum logic {
        ARB_IDLE    = 1'b0,
        ARB_RD_RESP = 1'b1
    } arb_state_t;

    localparam logic [1:0]  MEM_BYTE  = 2'd0;
    localparam logic [1:0]  MEM_HALF  = 2'd1;
    localparam logic [1:0]  MEM_WORD  = 2'd2;
    localparam logic [31:0] MMIO_BASE = 32'h0001_0000;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] din;
        logic [1:0]  size;
        logic        sign;
    } mem_req_t;

endpackage

// File: rtl/otter_starve_ctr.sv
// Saturating 4-bit count of CPU grants taken while DMA waits; flags when DMA must go next.
module otter_starve_ctr #(
    parameter int unsigned LIMIT = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_atLimit
);

    logic [3:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= 4'd0;
        end else if (i_clr) begin
            r_count <= 4'd0;
        end else if (i_inc && (r_count != 4'hF)) begin
            r_count <= r_count + 4'd1;
        end
    end

    assign o_atLimit = (32'(r_count) >= LIMIT);

endmodule

// File: rtl/otter_dmem_arbiter.sv
// Shares the OTTER memory data port between the CPU MEM stage and a DMA/debug requester,
// sequencing the memory's one-cycle synchronous read and holding address/size/sign through it.
module otter_dmem_arbiter
    import otter_mem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CPU_REQ,
    input  logic        CPU_WE,
    input  logic [31:0] CPU_ADDR,
    input  logic [31:0] CPU_DIN,
    input  logic [1:0]  CPU_SIZE,
    input  logic        CPU_SIGN,
    output logic        CPU_GNT,
    output logic        CPU_RVALID,
    output logic [31:0] CPU_RDATA,
    input  logic        DMA_REQ,
    input  logic        DMA_WE,
    input  logic [31:0] DMA_ADDR,
    input  logic [31:0] DMA_DIN,
    input  logic [1:0]  DMA_SIZE,
    input  logic        DMA_SIGN,
    output logic        DMA_GNT,
    output logic        DMA_RVALID,
    output logic [31:0] DMA_RDATA,
    output logic        MEM_RDEN2,
    output logic        MEM_WE2,
    output logic [31:0] MEM_ADDR2,
    output logic [31:0] MEM_DIN2,
    output logic [1:0]  MEM_SIZE,
    output logic        MEM_SIGN,
    input  logic [31:0] MEM_DOUT2
);

    arb_state_t  r_state, w_nextState;
    logic        r_ownerDma;
    logic [31:0] r_addr, r_din;
    logic [1:0]  r_size;
    logic        r_sign;

    mem_req_t    w_cpuFields, w_dmaFields, w_win;
    logic        w_idle, w_cpuWin, w_dmaWin, w_readGrant, w_atLimit;

    assign w_cpuFields = '{we: CPU_WE, addr: CPU_ADDR, din: CPU_DIN, size: CPU_SIZE, sign: CPU_SIGN};
    assign w_dmaFields = '{we: DMA_WE, addr: DMA_ADDR, din: DMA_DIN, size: DMA_SIZE, sign: DMA_SIGN};

    // CPU has priority unless DMA has been passed over STARVE_LIMIT times in a row.
    assign w_idle      = (r_state == ARB_IDLE) && !RST;
    assign w_cpuWin    = w_idle && CPU_REQ && (!DMA_REQ || !w_atLimit);
    assign w_dmaWin    = w_idle && DMA_REQ && !w_cpuWin;
    assign w_win       = w_cpuWin ? w_cpuFields : w_dmaFields;
    assign w_readGrant = (w_cpuWin || w_dmaWin) && !w_win.we;

    otter_starve_ctr #(
        .LIMIT(STARVE_LIMIT)
    ) u_starveCtr (
        .i_clk    (CLK),
        .i_rst    (RST),
        .i_inc    (w_cpuWin && DMA_REQ),
        .i_clr    (w_idle && (w_dmaWin || !DMA_REQ)),
        .o_atLimit(w_atLimit)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = ARB_IDLE;
        if ((r_state == ARB_IDLE) && w_readGrant) begin
            w_nextState = ARB_RD_RESP;
        end
    end

    // The memory's output mux is combinational on addr/size/sign, so they stay latched for the data cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ownerDma <= 1'b0;
            r_addr     <= 32'd0;
            r_din      <= 32'd0;
            r_size     <= 2'd0;
            r_sign     <= 1'b0;
        end else if (w_readGrant) begin
            r_ownerDma <= w_dmaWin;
            r_addr     <= w_win.addr;
            r_din      <= w_win.din;
            r_size     <= w_win.size;
            r_sign     <= w_win.sign;
        end
    end

    always_comb begin
        CPU_GNT    = 1'b0;
        DMA_GNT    = 1'b0;
        CPU_RVALID = 1'b0;
        DMA_RVALID = 1'b0;
        CPU_RDATA  = 32'd0;
        DMA_RDATA  = 32'd0;
        MEM_RDEN2  = 1'b0;
        MEM_WE2    = 1'b0;
        MEM_ADDR2  = r_addr;
        MEM_DIN2   = r_din;
        MEM_SIZE   = r_size;
        MEM_SIGN   = r_sign;
        if (RST) begin
            MEM_ADDR2 = 32'd0;
            MEM_DIN2  = 32'd0;
            MEM_SIZE  = 2'd0;
            MEM_SIGN  = 1'b0;
        end else if (r_state == ARB_RD_RESP) begin
            if (r_ownerDma) begin
                DMA_RVALID = 1'b1;
                DMA_RDATA  = MEM_DOUT2;
            end else begin
                CPU_RVALID = 1'b1;
                CPU_RDATA  = MEM_DOUT2;
            end
        end else if (w_cpuWin || w_dmaWin) begin
            CPU_GNT   = w_cpuWin;
            DMA_GNT   = w_dmaWin;
            MEM_WE2   = w_win.we;
            MEM_RDEN2 = !w_win.we;
            MEM_ADDR2 = w_win.addr;
            MEM_DIN2  = w_win.din;
            MEM_SIZE  = w_win.size;
            MEM_SIGN  = w_win.sign;
        end
    end

endmodule

// File: tb/tb_otter_dmem_arbiter.sv
// Directed scenarios plus randomized traffic, checked every cycle against a transaction-level
// reference model of the arbiter and a behavioural model of the OTTER data memory.
module tb_otter_dmem_arbiter;
    import otter_mem_pkg::*;

    localparam int unsigned STARVE_LIMIT = 4;

    logic        CLK, RST;
    logic        CPU_REQ, DMA_REQ;
    mem_req_t    cpuF, dmaF;
    logic        CPU_GNT, CPU_RVALID, DMA_GNT, DMA_RVALID;
    logic [31:0] CPU_RDATA, DMA_RDATA;
    logic        MEM_RDEN2, MEM_WE2, MEM_SIGN;
    logic [31:0] MEM_ADDR2, MEM_DIN2, MEM_DOUT2;
    logic [1:0]  MEM_SIZE;

    int vecCount  = 0;
    int missCount = 0;

    otter_dmem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .CLK(CLK), .RST(RST),
        .CPU_REQ(CPU_REQ), .CPU_WE(cpuF.we), .CPU_ADDR(cpuF.addr), .CPU_DIN(cpuF.din),
        .CPU_SIZE(cpuF.size), .CPU_SIGN(cpuF.sign),
        .CPU_GNT(CPU_GNT), .CPU_RVALID(CPU_RVALID), .CPU_RDATA(CPU_RDATA),
        .DMA_REQ(DMA_REQ), .DMA_WE(dmaF.we), .DMA_ADDR(dmaF.addr), .DMA_DIN(dmaF.din),
        .DMA_SIZE(dmaF.size), .DMA_SIGN(dmaF.sign),
        .DMA_GNT(DMA_GNT), .DMA_RVALID(DMA_RVALID), .DMA_RDATA(DMA_RDATA),
        .MEM_RDEN2(MEM_RDEN2), .MEM_WE2(MEM_WE2), .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2),
        .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN), .MEM_DOUT2(MEM_DOUT2)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [31:0] loadExtract(input logic [31:0] word, input logic [1:0] a,
                                                input logic [1:0] size, input logic sign);
        logic [31:0] sh;
        sh = word >> (8 * a);
        case (size)
            MEM_BYTE: return sign ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            MEM_HALF: return sign ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default:  return word;
        endcase
    endfunction

    function automatic logic [31:0] storeMerge(input logic [31:0] old, input logic [1:0] a,
                                               input logic [1:0] size, input logic [31:0] din);
        logic [31:0] w;
        w = old;
        case (size)
            MEM_BYTE: w[8*a +: 8]     = din[7:0];
            MEM_HALF: w[16*a[1] +: 16] = din[15:0];
            default:  w = din;
        endcase
        return w;
    endfunction

    // Behavioural OTTER data memory: registered word read, combinational sizing on live addr/size/sign.
    logic [31:0] mem [0:1023];
    logic [31:0] memWord;

    initial begin
        memWord = 32'd0;
        for (int i = 0; i < 1024; i++) mem[i] = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
    end

    always @(posedge CLK) begin
        if (MEM_RDEN2) memWord = mem[MEM_ADDR2[11:2]];
        if (MEM_WE2) mem[MEM_ADDR2[11:2]] = storeMerge(mem[MEM_ADDR2[11:2]], MEM_ADDR2[1:0], MEM_SIZE, MEM_DIN2);
    end

    assign MEM_DOUT2 = loadExtract(memWord, MEM_ADDR2[1:0], MEM_SIZE, MEM_SIGN);

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic cReq, input mem_req_t cf, input logic dReq, input mem_req_t df);
        CPU_REQ = cReq;
        cpuF    = cf;
        DMA_REQ = dReq;
        dmaF    = df;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic atSample();
        @(negedge CLK);
    endtask

    function automatic mem_req_t randReq();
        mem_req_t r;
        r.we   = 1'($urandom_range(0, 1));
        r.size = 2'($urandom_range(0, 2));
        r.sign = 1'($urandom_range(0, 1));
        r.din  = $urandom;
        r.addr = 32'($urandom_range(0, 4095));
        if (r.size == MEM_HALF) r.addr[0] = 1'b0;
        if (r.size == MEM_WORD) r.addr[1:0] = 2'b00;
        if ($urandom_range(0, 7) == 0) r.addr = r.addr + MMIO_BASE;
        return r;
    endfunction

    // Reference model: one pending read at most; grants follow priority and the starvation rule.
    logic        mBusy = 1'b0, mOwnerDma = 1'b0, mCpuWon = 1'b0, mDmaWon = 1'b0;
    logic [31:0] mLatAddr = 32'd0, mExpData = 32'd0;
    logic [1:0]  mLatSize = 2'd0;
    logic        mLatSign = 1'b0;
    int          mCount = 0;

    always @(negedge CLK) begin
        logic     cw, dw;
        mem_req_t w;
        mCpuWon = 1'b0;
        mDmaWon = 1'b0;
        if (RST) begin
            checkOutput("rst_gnt", {30'd0, CPU_GNT, DMA_GNT}, 32'd0);
            checkOutput("rst_rvalid", {30'd0, CPU_RVALID, DMA_RVALID}, 32'd0);
            checkOutput("rst_rdata", CPU_RDATA | DMA_RDATA, 32'd0);
            checkOutput("rst_memctl", {30'd0, MEM_RDEN2, MEM_WE2}, 32'd0);
            checkOutput("rst_memaddr", MEM_ADDR2, 32'd0);
            checkOutput("rst_memdin", MEM_DIN2, 32'd0);
            checkOutput("rst_sizesign", {29'd0, MEM_SIZE, MEM_SIGN}, 32'd0);
            mBusy = 1'b0; mCount = 0; mLatAddr = 32'd0; mLatSize = 2'd0; mLatSign = 1'b0;
        end else if (mBusy) begin
            checkOutput("resp_gnt", {30'd0, CPU_GNT, DMA_GNT}, 32'd0);
            checkOutput("resp_cpu_rvalid", CPU_RVALID, !mOwnerDma);
            checkOutput("resp_dma_rvalid", DMA_RVALID, mOwnerDma);
            checkOutput("resp_cpu_rdata", CPU_RDATA, mOwnerDma ? 32'd0 : mExpData);
            checkOutput("resp_dma_rdata", DMA_RDATA, mOwnerDma ? mExpData : 32'd0);
            checkOutput("resp_memctl", {30'd0, MEM_RDEN2, MEM_WE2}, 32'd0);
            checkOutput("resp_hold", {MEM_ADDR2[28:0], MEM_SIZE, MEM_SIGN}, {mLatAddr[28:0], mLatSize, mLatSign});
            mBusy = 1'b0;
        end else begin
            cw = CPU_REQ && (!DMA_REQ || (mCount < STARVE_LIMIT));
            dw = !cw && DMA_REQ;
            checkOutput("cpu_gnt", CPU_GNT, cw);
            checkOutput("dma_gnt", DMA_GNT, dw);
            checkOutput("idle_rvalid", {30'd0, CPU_RVALID, DMA_RVALID}, 32'd0);
            if (cw || dw) begin
                w = cw ? cpuF : dmaF;
                checkOutput("mem_we", MEM_WE2, w.we);
                checkOutput("mem_rden", MEM_RDEN2, !w.we);
                checkOutput("mem_addr", MEM_ADDR2, w.addr);
                checkOutput("mem_sizesign", {29'd0, MEM_SIZE, MEM_SIGN}, {29'd0, w.size, w.sign});
                if (w.we) begin
                    checkOutput("mem_din", MEM_DIN2, w.din);
                end else begin
                    mBusy     = 1'b1;
                    mOwnerDma = dw;
                    mLatAddr  = w.addr;
                    mLatSize  = w.size;
                    mLatSign  = w.sign;
                    mExpData  = loadExtract(mem[w.addr[11:2]], w.addr[1:0], w.size, w.sign);
                end
            end else begin
                checkOutput("noreq_memctl", {30'd0, MEM_RDEN2, MEM_WE2}, 32'd0);
                checkOutput("noreq_addr", MEM_ADDR2, mLatAddr);
            end
            mCpuWon = cw;
            mDmaWon = dw;
            if (cw && DMA_REQ) mCount = (mCount >= 15) ? 15 : mCount + 1;
            else if (dw || !DMA_REQ) mCount = 0;
        end
    end

    initial begin
        mem_req_t idle, dmaSt, dmaLd;
        idle  = '0;
        dmaSt = '{we: 1'b1, addr: 32'h300, din: 32'hCAFE_0300, size: MEM_WORD, sign: 1'b0};
        dmaLd = '{we: 1'b0, addr: 32'h300, din: 32'd0, size: MEM_WORD, sign: 1'b0};
        RST = 1'b1;
        applyStimulus(1'b0, idle, 1'b0, idle);
        repeat (2) tick();
        atSample();
        checkOutput("reset_gnt", {30'd0, CPU_GNT, DMA_GNT}, 32'd0);
        tick();
        RST = 1'b0;
        checkOutput("reset_ctr", 32'(dut.u_starveCtr.r_count), 32'd0);

        // Word store then load back with DMA idle.
        applyStimulus(1'b1, '{we: 1'b1, addr: 32'h100, din: 32'hDEAD_BEEF, size: MEM_WORD, sign: 1'b0}, 1'b0, idle);
        atSample();
        checkOutput("t1_sw_gnt", CPU_GNT, 1'b1);
        tick();
        applyStimulus(1'b1, '{we: 1'b0, addr: 32'h100, din: 32'd0, size: MEM_WORD, sign: 1'b0}, 1'b0, idle);
        atSample();
        checkOutput("t1_lw_gnt", CPU_GNT, 1'b1);
        checkOutput("t1_rden_c0", MEM_RDEN2, 1'b1);
        tick();
        applyStimulus(1'b0, idle, 1'b0, idle);
        atSample();
        checkOutput("t1_rvalid", CPU_RVALID, 1'b1);
        checkOutput("t1_rdata", CPU_RDATA, 32'hDEAD_BEEF);
        checkOutput("t1_rden_c1", MEM_RDEN2, 1'b0);

        // Signed byte load; CPU fields change right after the grant.
        tick();
        applyStimulus(1'b1, '{we: 1'b1, addr: 32'h140, din: 32'h0000_8000, size: MEM_WORD, sign: 1'b0}, 1'b0, idle);
        atSample();
        tick();
        applyStimulus(1'b1, '{we: 1'b0, addr: 32'h141, din: 32'd0, size: MEM_BYTE, sign: 1'b0}, 1'b0, idle);
        atSample();
        checkOutput("t2_gnt", CPU_GNT, 1'b1);
        tick();
        applyStimulus(1'b0, '{we: 1'b0, addr: 32'h200, din: 32'd0, size: MEM_WORD, sign: 1'b1}, 1'b0, idle);
        atSample();
        checkOutput("t2_rdata", CPU_RDATA, 32'hFFFF_FF80);
        checkOutput("t2_addr_hold", MEM_ADDR2, 32'h141);
        checkOutput("t2_size_hold", MEM_SIZE, MEM_BYTE);

        // Continuous CPU stores against a waiting DMA store.
        tick();
        applyStimulus(1'b0, idle, 1'b0, idle);
        atSample();
        for (int k = 0; k < 5; k++) begin
            tick();
            applyStimulus(1'b1, '{we: 1'b1, addr: 32'h400 + 32'(4 * k), din: 32'(k), size: MEM_WORD, sign: 1'b0},
                          1'b1, dmaSt);
            atSample();
            checkOutput("t3_cpu_gnt", CPU_GNT, k < 4);
            checkOutput("t3_dma_gnt", DMA_GNT, k == 4);
        end
        tick();
        applyStimulus(1'b0, idle, 1'b0, idle);
        checkOutput("t3_ctr_cleared", 32'(dut.u_starveCtr.r_count), 32'd0);
        atSample();

        // Simultaneous reads with count 0: CPU first, DMA next idle cycle.
        tick();
        applyStimulus(1'b1, '{we: 1'b0, addr: 32'h100, din: 32'd0, size: MEM_WORD, sign: 1'b0}, 1'b1, dmaLd);
        atSample();
        checkOutput("t4_cpu_first", {30'd0, CPU_GNT, DMA_GNT}, 32'd2);
        tick();
        applyStimulus(1'b0, idle, 1'b1, dmaLd);
        atSample();
        checkOutput("t4_cpu_resp", {30'd0, CPU_RVALID, DMA_RVALID}, 32'd2);
        checkOutput("t4_cpu_rdata", CPU_RDATA, 32'hDEAD_BEEF);
        tick();
        atSample();
        checkOutput("t4_dma_gnt", DMA_GNT, 1'b1);
        tick();
        applyStimulus(1'b0, idle, 1'b0, idle);
        atSample();
        checkOutput("t4_dma_resp", {30'd0, CPU_RVALID, DMA_RVALID}, 32'd1);
        checkOutput("t4_dma_rdata", DMA_RDATA, 32'hCAFE_0300);

        // DMA store to an MMIO address passes straight through.
        tick();
        applyStimulus(1'b0, idle, 1'b1, '{we: 1'b1, addr: 32'h11000, din: 32'h1234_5678, size: MEM_WORD, sign: 1'b0});
        atSample();
        checkOutput("t5_gnt", DMA_GNT, 1'b1);
        checkOutput("t5_we", MEM_WE2, 1'b1);
        checkOutput("t5_addr", MEM_ADDR2, 32'h11000);
        checkOutput("t5_din", MEM_DIN2, 32'h1234_5678);
        tick();
        applyStimulus(1'b0, idle, 1'b0, idle);
        atSample();
        checkOutput("t5_no_rvalid", {30'd0, CPU_RVALID, DMA_RVALID}, 32'd0);

        // Reset during the response cycle drops the read.
        tick();
        applyStimulus(1'b1, '{we: 1'b0, addr: 32'h100, din: 32'd0, size: MEM_WORD, sign: 1'b0}, 1'b0, idle);
        atSample();
        checkOutput("t6_gnt", CPU_GNT, 1'b1);
        tick();
        RST = 1'b1;
        applyStimulus(1'b0, idle, 1'b0, idle);
        atSample();
        checkOutput("t6_no_rvalid", CPU_RVALID, 1'b0);
        checkOutput("t6_rdata", CPU_RDATA, 32'd0);
        tick();
        RST = 1'b0;
        applyStimulus(1'b0, idle, 1'b1, '{we: 1'b0, addr: 32'h100, din: 32'd0, size: MEM_WORD, sign: 1'b0});
        atSample();
        checkOutput("t6_new_gnt", DMA_GNT, 1'b1);
        tick();
        applyStimulus(1'b0, idle, 1'b0, idle);
        atSample();
        checkOutput("t6_dma_rdata", DMA_RDATA, 32'hDEAD_BEEF);

        // Random traffic: requests held until granted, occasional withdrawal and reset.
        for (int i = 0; i < 3000; i++) begin
            tick();
            RST = ($urandom_range(0, 63) == 0);
            if (!CPU_REQ || mCpuWon) begin
                CPU_REQ = ($urandom_range(0, 9) < 7);
                cpuF    = randReq();
            end else if ($urandom_range(0, 15) == 0) begin
                CPU_REQ = 1'b0;
            end
            if (!DMA_REQ || mDmaWon) begin
                DMA_REQ = ($urandom_range(0, 9) < 6);
                dmaF    = randReq();
            end else if ($urandom_range(0, 31) == 0) begin
                DMA_REQ = 1'b0;
            end
        end
        tick();
        RST = 1'b0;
        applyStimulus(1'b0, idle, 1'b0, idle);
        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
